drive_sequencer: RTL and testbench
==================================

# drive_sequencer

Motion controller for the line-following car. Takes the three tracker sensor bits, the ultrasonic obstacle flag and a start pulse, and decides the drive state. It then produces per-wheel direction codes and slew-limited PWM duty commands for the motor PWM generators. It sits between the sensor front-ends (tracker, sonic) and the motor block, and replaces the fixed forward/brake direction mux.

## Interface
- DUTY_W, 8: duty command width
- DUTY_CRUISE, 200: straight-line duty
- DUTY_SLOW, 80: inner-wheel duty when steering; both wheels' duty when searching
- RAMP_STEP, 50: maximum duty change per ramp tick
- RAMP_DIV, 1: clock cycles per ramp tick (≥1)
- BRAKE_HOLD, 4: cycles held in BRAKE after obstacle clears
- LOST_TIMEOUT, 16: cycles in SEARCH without line before giving up
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  single-cycle pulse (debounced/one-pulsed upstream)
- sens_l, sens_m, sens_r  in  1 each  1 = sensor over line; already synchronised
- obstacle  in  1  level; 1 = object inside stop distance
- left_dir, right_dir  out  2 each  10 forward, 01 reverse, 11 brake, 00 coast
- left_duty, right_duty  out  DUTY_W each  PWM duty command
- state_o  out  3  current state encoding (debug)
- lost  out  1  sticky; line lost and timed out

## Operation
- States: IDLE, FOLLOW, STEER_L, STEER_R, SEARCH, BRAKE.
- IDLE: dirs 00, duties 0. start moves to FOLLOW and clears lost. start in any other state is ignored.
- Sensor decode (l,m,r), evaluated in FOLLOW/STEER_*/SEARCH:
  - 010 or 111 -> FOLLOW
  - 110 or 100 -> STEER_L
  - 011 or 001 -> STEER_R
  - 000 -> SEARCH
  - 101 -> hold current state
- last_side register: set to L on entering STEER_L, R on entering STEER_R. Reset value L.
- Wheel targets:
  - FOLLOW: both forward at CRUISE.
  - STEER_L: left forward SLOW, right forward CRUISE. STEER_R is the mirror.
  - SEARCH: pivot toward last_side; inner wheel reverse SLOW, outer wheel forward SLOW.
- SEARCH counter counts cycles in SEARCH. At LOST_TIMEOUT it goes to IDLE and sets lost=1. Any line pattern exits SEARCH per the decode table and clears the counter.
- obstacle=1 in any non-IDLE state -> BRAKE. This has priority over sensor decode. In BRAKE: dirs 11, duties 0, applied immediately with no ramp. BRAKE stays while obstacle=1. After obstacle falls, BRAKE holds BRAKE_HOLD further cycles and then goes to FOLLOW. If obstacle reasserts during the hold, the hold count restarts.
- Ramp, per wheel, once every RAMP_DIV cycles:
  - If commanded dir equals current dir, duty moves toward the target by at most RAMP_STEP, clamped exactly at the target with no overshoot.
  - If commanded dir differs and duty > 0, duty ramps toward 0 while dir is kept.
  - If commanded dir differs and duty = 0, dir switches on that tick; ramp up starts on the next tick.
  - Arithmetic is unsigned DUTY_W with saturation at 0 and at the target.
- BRAKE/IDLE entry forces duty 0 and sets dir (11/00) directly. Leaving BRAKE, ramp-up starts from 0 with dir 10.

## Timing
- All outputs registered.
- Reset values: state IDLE, dirs 00, duties 0, lost 0, last_side L, all counters 0, ramp divider 0.
- Input sampled at edge N -> state change visible after edge N.
- Duty/dir follow the new state from the next ramp tick, so first ramp step appears at edge N+1 when RAMP_DIV=1.
- obstacle sampled high at edge N -> dirs 11 and duties 0 visible after edge N (1-cycle latency). This is the safety path and must not go through the ramp.
- rst during motion: everything returns to reset values after that edge. No ramp-down.
- start and obstacle in the same cycle while in IDLE: go to FOLLOW. Obstacle is evaluated from the next cycle, so the state is BRAKE one cycle later.

## Structure
- Package drive_pkg: state enum, direction code constants (DIR_FWD, DIR_REV, DIR_BRAKE, DIR_COAST).
- Sub-module wheel_ramp, instantiated twice:
  - Inputs: tick, force (zero/brake), target dir, target duty.
  - Outputs: dir, duty.
  - Contains the dir-change-through-zero logic.
- Top: FSM, sensor decode, hold/search counters, ramp tick divider, last_side.

## Test plan
- Default parameters. Reset, start, sens=010 -> state FOLLOW. Both dirs 10; duties 50,100,150,200 on consecutive cycles, then steady at 200.
- Cruising at 200, obstacle=1 for 3 cycles -> the next edge gives dirs 11, duties 0. Obstacle drops -> BRAKE for 4 more cycles, then FOLLOW, dirs 10, duties 50→200.
- Cruising, sens=110 -> STEER_L. left_duty 150,100,80 then holds 80; right_duty stays 200. Then sens=101 for 5 cycles -> state and duties unchanged.
- After STEER_L, sens=000 -> SEARCH. left_duty ramps 80,30,0, then left_dir becomes 01, then duty 50,80. right_duty ramps 200→80 forward. At 16 cycles -> IDLE, lost=1, dirs 00, duties 0. start -> lost=0, FOLLOW.
- rst pulsed while duty=100 mid-ramp -> all outputs at reset values after that edge. start pulse while in FOLLOW -> no effect.

Source files
------------

// File: rtl/drive_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : drive_pkg
// Purpose : Shared types and constants for the drive sequencer: FSM state
//           encoding, last-turn side, wheel direction codes, sensor decode.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
package drive_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FOLLOW  = 3'd1,
    ST_STEER_L = 3'd2,
    ST_STEER_R = 3'd3,
    ST_SEARCH  = 3'd4,
    ST_BRAKE   = 3'd5
  } state_t;

  typedef enum logic {
    SIDE_L = 1'b0,
    SIDE_R = 1'b1
  } side_t;

  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_REV   = 2'b01;
  localparam logic [1:0] DIR_BRAKE = 2'b11;
  localparam logic [1:0] DIR_COAST = 2'b00;

  // Line pattern to tracking state; the ambiguous 101 pattern keeps the
  // current state.
  function automatic state_t decode_sensors(input logic [2:0] lmr, input state_t cur);
    state_t res;
    case (lmr)
      3'b010, 3'b111: res = ST_FOLLOW;
      3'b110, 3'b100: res = ST_STEER_L;
      3'b011, 3'b001: res = ST_STEER_R;
      3'b000:         res = ST_SEARCH;
      default:        res = cur;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/drive_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : drive_sequencer_if
// Purpose : Sensor inputs and motor command outputs of the drive sequencer.
// Ports   : start, sens_l/m/r, obstacle            (to sequencer)
//           left/right_dir, left/right_duty,
//           state_o, lost                          (from sequencer)
//           master = sensor/motor side, slave = sequencer
// Rev     : 1.0 - initial release
// ============================================================================
interface drive_sequencer_if #(
  parameter int DUTY_W = 8
);
  logic              start;
  logic              sens_l;
  logic              sens_m;
  logic              sens_r;
  logic              obstacle;
  logic [1:0]        left_dir;
  logic [1:0]        right_dir;
  logic [DUTY_W-1:0] left_duty;
  logic [DUTY_W-1:0] right_duty;
  logic [2:0]        state_o;
  logic              lost;

  modport master (
    output start, sens_l, sens_m, sens_r, obstacle,
    input  left_dir, right_dir, left_duty, right_duty, state_o, lost
  );

  modport slave (
    input  start, sens_l, sens_m, sens_r, obstacle,
    output left_dir, right_dir, left_duty, right_duty, state_o, lost
  );
endinterface
`default_nettype wire

// File: rtl/drive_sequencer_wheel_ramp.sv
`default_nettype none
// ============================================================================
// Module  : wheel_ramp
// Purpose : Per-wheel slew limiter. Moves duty toward the target by at most
//           RAMP_STEP per tick; a direction reversal first ramps to zero,
//           then flips direction, then ramps up again.
// Ports   : clk, rst            clock, synchronous active-high reset
//           tick                ramp step enable
//           force_en, force_dir immediate override: duty 0, dir force_dir
//           target_dir/duty     commanded direction and duty
//           dir, duty           registered wheel command
// Rev     : 1.0 - initial release
// ============================================================================
module wheel_ramp
  import drive_pkg::*;
#(
  parameter int DUTY_W    = 8,
  parameter int RAMP_STEP = 50
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              tick,
  input  wire logic              force_en,
  input  wire logic [1:0]        force_dir,
  input  wire logic [1:0]        target_dir,
  input  wire logic [DUTY_W-1:0] target_duty,
  output logic      [1:0]        dir,
  output logic      [DUTY_W-1:0] duty
);

  localparam logic [DUTY_W-1:0] c_step = DUTY_W'(RAMP_STEP);

  logic [1:0]        r_dir;
  logic [DUTY_W-1:0] r_duty;
  logic [1:0]        w_next_dir;
  logic [DUTY_W-1:0] w_next_duty;
  logic [DUTY_W-1:0] w_up_gap;
  logic [DUTY_W-1:0] w_dn_gap;
  logic              w_stopped_dir;

  assign w_up_gap = target_duty - r_duty;
  assign w_dn_gap = r_duty - target_duty;
  // Coast and brake only ever carry zero duty, so the wheel may take the
  // commanded direction immediately and start ramping on the same tick.
  assign w_stopped_dir = (r_dir == DIR_COAST) || (r_dir == DIR_BRAKE);

  always_comb begin
    w_next_dir  = r_dir;
    w_next_duty = r_duty;
    if (force_en) begin
      w_next_dir  = force_dir;
      w_next_duty = '0;
    end else if (tick) begin
      if (w_stopped_dir || (r_dir == target_dir)) begin
        w_next_dir = target_dir;
        if (r_duty < target_duty) begin
          w_next_duty = (w_up_gap > c_step) ? r_duty + c_step : target_duty;
        end else begin
          w_next_duty = (w_dn_gap > c_step) ? r_duty - c_step : target_duty;
        end
      end else if (r_duty != '0) begin
        // Reversal requested: keep the current direction while slowing down.
        w_next_duty = (r_duty > c_step) ? r_duty - c_step : '0;
      end else begin
        w_next_dir = target_dir;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir  <= DIR_COAST;
      r_duty <= '0;
    end else begin
      r_dir  <= w_next_dir;
      r_duty <= w_next_duty;
    end
  end

  assign dir  = r_dir;
  assign duty = r_duty;

endmodule
`default_nettype wire

// File: rtl/drive_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : drive_sequencer
// Purpose : Line-following motion controller. Decodes tracker sensors and the
//           obstacle flag into a drive state and produces slew-limited wheel
//           direction/duty commands.
// Ports   : clk, rst   clock, synchronous active-high reset
//           bus        drive_sequencer_if.slave (sensors in, motor cmds out)
// Rev     : 1.0 - initial release
// ============================================================================
module drive_sequencer
  import drive_pkg::*;
#(
  parameter int DUTY_W       = 8,
  parameter int DUTY_CRUISE  = 200,
  parameter int DUTY_SLOW    = 80,
  parameter int RAMP_STEP    = 50,
  parameter int RAMP_DIV     = 1,
  parameter int BRAKE_HOLD   = 4,
  parameter int LOST_TIMEOUT = 16
) (
  input wire logic          clk,
  input wire logic          rst,
  drive_sequencer_if.slave  bus
);

  localparam int SEARCH_W = $clog2(LOST_TIMEOUT + 1);
  localparam int HOLD_W   = $clog2(BRAKE_HOLD + 1);
  localparam int DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [DUTY_W-1:0] c_cruise = DUTY_W'(DUTY_CRUISE);
  localparam logic [DUTY_W-1:0] c_slow   = DUTY_W'(DUTY_SLOW);

  state_t              r_state;
  state_t              w_next_state;
  state_t              w_decoded;
  side_t               r_last_side;
  logic                r_lost;
  logic [SEARCH_W-1:0] r_search_cnt;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [DIV_W-1:0]    r_div_cnt;
  logic                w_tick;

  logic [1:0]          w_l_dir;
  logic [1:0]          w_r_dir;
  logic [DUTY_W-1:0]   w_l_duty;
  logic [DUTY_W-1:0]   w_r_duty;
  logic                w_force;
  logic [1:0]          w_force_dir;

  assign w_tick    = (r_div_cnt == DIV_W'(RAMP_DIV - 1));
  assign w_decoded = decode_sensors({bus.sens_l, bus.sens_m, bus.sens_r}, r_state);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; obstacle outranks the sensor decode in every moving state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_next_state = ST_FOLLOW;
      end
      ST_FOLLOW, ST_STEER_L, ST_STEER_R: begin
        w_next_state = bus.obstacle ? ST_BRAKE : w_decoded;
      end
      ST_SEARCH: begin
        if (bus.obstacle)
          w_next_state = ST_BRAKE;
        else if ((w_decoded == ST_SEARCH) && (r_search_cnt == SEARCH_W'(LOST_TIMEOUT - 1)))
          w_next_state = ST_IDLE;
        else
          w_next_state = w_decoded;
      end
      ST_BRAKE: begin
        if (!bus.obstacle && (r_hold_cnt == HOLD_W'(BRAKE_HOLD))) w_next_state = ST_FOLLOW;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Wheel targets follow the current state; stop/brake entry and brake exit
  // bypass the ramp so the safety path has a single cycle of latency.
  always_comb begin
    w_l_dir     = DIR_COAST;
    w_r_dir     = DIR_COAST;
    w_l_duty    = '0;
    w_r_duty    = '0;
    w_force     = 1'b0;
    w_force_dir = DIR_COAST;
    case (r_state)
      ST_FOLLOW: begin
        w_l_dir = DIR_FWD; w_l_duty = c_cruise;
        w_r_dir = DIR_FWD; w_r_duty = c_cruise;
      end
      ST_STEER_L: begin
        w_l_dir = DIR_FWD; w_l_duty = c_slow;
        w_r_dir = DIR_FWD; w_r_duty = c_cruise;
      end
      ST_STEER_R: begin
        w_l_dir = DIR_FWD; w_l_duty = c_cruise;
        w_r_dir = DIR_FWD; w_r_duty = c_slow;
      end
      ST_SEARCH: begin
        // Pivot toward the side the line was last seen on
        w_l_duty = c_slow;
        w_r_duty = c_slow;
        w_l_dir  = (r_last_side == SIDE_L) ? DIR_REV : DIR_FWD;
        w_r_dir  = (r_last_side == SIDE_L) ? DIR_FWD : DIR_REV;
      end
      ST_BRAKE: begin
        w_l_dir = DIR_BRAKE;
        w_r_dir = DIR_BRAKE;
      end
      default: ;
    endcase
    if (w_next_state == ST_BRAKE) begin
      w_force     = 1'b1;
      w_force_dir = DIR_BRAKE;
    end else if (w_next_state == ST_IDLE) begin
      w_force     = 1'b1;
      w_force_dir = DIR_COAST;
    end else if (r_state == ST_BRAKE) begin
      w_force     = 1'b1;
      w_force_dir = DIR_FWD;
    end
  end

  // Counters, ramp divider, lost flag and last turn side
  always_ff @(posedge clk) begin
    if (rst) begin
      r_search_cnt <= '0;
      r_hold_cnt   <= '0;
      r_div_cnt    <= '0;
      r_lost       <= 1'b0;
      r_last_side  <= SIDE_L;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;

      if ((r_state == ST_SEARCH) && (w_next_state == ST_SEARCH))
        r_search_cnt <= r_search_cnt + 1'b1;
      else
        r_search_cnt <= '0;

      // Hold count only advances while the obstacle is clear
      if ((r_state == ST_BRAKE) && (w_next_state == ST_BRAKE) && !bus.obstacle)
        r_hold_cnt <= r_hold_cnt + 1'b1;
      else
        r_hold_cnt <= '0;

      if ((r_state == ST_IDLE) && bus.start)
        r_lost <= 1'b0;
      else if ((r_state == ST_SEARCH) && (w_next_state == ST_IDLE))
        r_lost <= 1'b1;

      if (w_next_state == ST_STEER_L)      r_last_side <= SIDE_L;
      else if (w_next_state == ST_STEER_R) r_last_side <= SIDE_R;
    end
  end

  wheel_ramp #(.DUTY_W(DUTY_W), .RAMP_STEP(RAMP_STEP)) u_wheel_l (
    .clk         (clk),
    .rst         (rst),
    .tick        (w_tick),
    .force_en    (w_force),
    .force_dir   (w_force_dir),
    .target_dir  (w_l_dir),
    .target_duty (w_l_duty),
    .dir         (bus.left_dir),
    .duty        (bus.left_duty)
  );

  wheel_ramp #(.DUTY_W(DUTY_W), .RAMP_STEP(RAMP_STEP)) u_wheel_r (
    .clk         (clk),
    .rst         (rst),
    .tick        (w_tick),
    .force_en    (w_force),
    .force_dir   (w_force_dir),
    .target_dir  (w_r_dir),
    .target_duty (w_r_duty),
    .dir         (bus.right_dir),
    .duty        (bus.right_duty)
  );

  assign bus.state_o = r_state;
  assign bus.lost    = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_drive_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_drive_sequencer
// Purpose : Self-checking bench for drive_sequencer. Each scenario task builds
//           a table of per-cycle stimulus with the expected registered outputs,
//           pushes the expectation when the stimulus is applied and compares
//           it after the clock edge.
// Ports   : none
// Rev     : 1.0 - initial release
// ============================================================================
module tb_drive_sequencer;

  localparam int S_IDLE = 0, S_FOL = 1, S_SL = 2, S_SR = 3, S_SRCH = 4, S_BRK = 5;
  localparam int F = 2, R = 1, B = 3, C = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  drive_sequencer_if #(.DUTY_W(8)) bus ();

  drive_sequencer #(
    .DUTY_W(8), .DUTY_CRUISE(200), .DUTY_SLOW(80), .RAMP_STEP(50),
    .RAMP_DIV(1), .BRAKE_HOLD(4), .LOST_TIMEOUT(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] ld;
    logic [7:0] lu;
    logic [1:0] rd;
    logic [7:0] ru;
    logic       lost;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic       start;
    logic [2:0] sens;
    logic       obs;
  } stim_t;

  typedef struct packed {
    stim_t s;
    obs_t  e;
  } step_t;

  obs_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic step_t mk(input int r, input int s, input logic [2:0] sens, input int o,
                               input int st, input int ld, input int lu,
                               input int rd, input int ru, input int l);
    step_t t;
    t.s = {1'(r), 1'(s), sens, 1'(o)};
    t.e = {3'(st), 2'(ld), 8'(lu), 2'(rd), 8'(ru), 1'(l)};
    return t;
  endfunction

  function automatic obs_t observe();
    return {bus.state_o, bus.left_dir, bus.left_duty, bus.right_dir, bus.right_duty, bus.lost};
  endfunction

  task automatic drive(input stim_t s);
    rst          = s.rst;
    bus.start    = s.start;
    bus.sens_l   = s.sens[2];
    bus.sens_m   = s.sens[1];
    bus.sens_r   = s.sens[0];
    bus.obstacle = s.obs;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t v[$];
    obs_t  got, e;
    v.push_back(mk(1, 0, 3'b010, 0, S_IDLE, C, 0, C, 0, 0));
    v.push_back(mk(1, 1, 3'b010, 1, S_IDLE, C, 0, C, 0, 0));
    v.push_back(mk(0, 0, 3'b010, 1, S_IDLE, C, 0, C, 0, 0));  // obstacle ignored in IDLE
    foreach (v[i]) begin
      sb.push_back(v[i].e);
      drive(v[i].s);
      got = observe();
      e   = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset[%0d] got st=%0d ld=%b lu=%0d rd=%b ru=%0d lost=%b required st=%0d ld=%b lu=%0d rd=%b ru=%0d lost=%b",
                 i, got.st, got.ld, got.lu, got.rd, got.ru, got.lost, e.st, e.ld, e.lu, e.rd, e.ru, e.lost);
      end
    end
  endtask

  task automatic test_start_ramp();
    step_t v[$];
    obs_t  got, e;
    v.push_back(mk(0, 1, 3'b010, 0, S_FOL, C, 0, C, 0, 0));
    for (int k = 1; k <= 4; k++) v.push_back(mk(0, 0, 3'b010, 0, S_FOL, F, 50*k, F, 50*k, 0));
    for (int k = 0; k < 2; k++)  v.push_back(mk(0, 0, 3'b010, 0, S_FOL, F, 200, F, 200, 0));
    foreach (v[i]) begin
      sb.push_back(v[i].e);
      drive(v[i].s);
      got = observe();
      e   = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL start_ramp[%0d] got st=%0d ld=%b lu=%0d rd=%b ru=%0d lost=%b required st=%0d ld=%b lu=%0d rd=%b ru=%0d lost=%b",
                 i, got.st, got.ld, got.lu, got.rd, got.ru, got.lost, e.st, e.ld, e.lu, e.rd, e.ru, e.lost);
      end
    end
  endtask

  task automatic test_obstacle();
    step_t v[$];
    obs_t  got, e;
    for (int k = 0; k < 3; k++) v.push_back(mk(0, 0, 3'b010, 1, S_BRK, B, 0, B, 0, 0));
    for (int k = 0; k < 4; k++) v.push_back(mk(0, 0, 3'b010, 0, S_BRK, B, 0, B, 0, 0));
    v.push_back(mk(0, 0, 3'b010, 0, S_FOL, F, 0, F, 0, 0));
    for (int k = 1; k <= 4; k++) v.push_back(mk(0, 0, 3'b010, 0, S_FOL, F, 50*k, F, 50*k, 0));
    // Hold restarts when the obstacle reappears mid-hold
    v.push_back(mk(0, 0, 3'b010, 1, S_BRK, B, 0, B, 0, 0));
    for (int k = 0; k < 2; k++) v.push_back(mk(0, 0, 3'b010, 0, S_BRK, B, 0, B, 0, 0));
    v.push_back(mk(0, 0, 3'b010, 1, S_BRK, B, 0, B, 0, 0));
    for (int k = 0; k < 4; k++) v.push_back(mk(0, 0, 3'b010, 0, S_BRK, B, 0, B, 0, 0));
    v.push_back(mk(0, 0, 3'b010, 0, S_FOL, F, 0, F, 0, 0));
    for (int k = 1; k <= 4; k++) v.push_back(mk(0, 0, 3'b010, 0, S_FOL, F, 50*k, F, 50*k, 0));
    foreach (v[i]) begin
      sb.push_back(v[i].e);
      drive(v[i].s);
      got = observe();
      e   = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL obstacle[%0d] got st=%0d ld=%b lu=%0d rd=%b ru=%0d lost=%b required st=%0d ld=%b lu=%0d rd=%b ru=%0d lost=%b",
                 i, got.st, got.ld, got.lu, got.rd, got.ru, got.lost, e.st, e.ld, e.lu, e.rd, e.ru, e.lost);
      end
    end
  endtask

  task automatic test_steer();
    step_t v[$];
    obs_t  got, e;
    v.push_back(mk(0, 0, 3'b110, 0, S_SL, F, 200, F, 200, 0));
    v.push_back(mk(0, 0, 3'b110, 0, S_SL, F, 150, F, 200, 0));
    v.push_back(mk(0, 0, 3'b110, 0, S_SL, F, 100, F, 200, 0));
    v.push_back(mk(0, 0, 3'b110, 0, S_SL, F,  80, F, 200, 0));
    v.push_back(mk(0, 0, 3'b110, 0, S_SL, F,  80, F, 200, 0));
    for (int k = 0; k < 5; k++) v.push_back(mk(0, 0, 3'b101, 0, S_SL, F, 80, F, 200, 0));
    v.push_back(mk(0, 0, 3'b001, 0, S_SR, F,  80, F, 200, 0));
    v.push_back(mk(0, 0, 3'b001, 0, S_SR, F, 130, F, 150, 0));
    v.push_back(mk(0, 0, 3'b011, 0, S_SR, F, 180, F, 100, 0));
    v.push_back(mk(0, 0, 3'b011, 0, S_SR, F, 200, F,  80, 0));
    v.push_back(mk(0, 0, 3'b100, 0, S_SL, F, 200, F,  80, 0));
    v.push_back(mk(0, 0, 3'b100, 0, S_SL, F, 150, F, 130, 0));
    v.push_back(mk(0, 0, 3'b110, 0, S_SL, F, 100, F, 180, 0));
    v.push_back(mk(0, 0, 3'b110, 0, S_SL, F,  80, F, 200, 0));
    foreach (v[i]) begin
      sb.push_back(v[i].e);
      drive(v[i].s);
      got = observe();
      e   = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL steer[%0d] got st=%0d ld=%b lu=%0d rd=%b ru=%0d lost=%b required st=%0d ld=%b lu=%0d rd=%b ru=%0d lost=%b",
                 i, got.st, got.ld, got.lu, got.rd, got.ru, got.lost, e.st, e.ld, e.lu, e.rd, e.ru, e.lost);
      end
    end
  endtask

  task automatic test_search();
    step_t v[$];
    obs_t  got, e;
    v.push_back(mk(0, 0, 3'b000, 0, S_SRCH, F, 80, F, 200, 0));
    v.push_back(mk(0, 0, 3'b000, 0, S_SRCH, F, 30, F, 150, 0));
    v.push_back(mk(0, 0, 3'b000, 0, S_SRCH, F,  0, F, 100, 0));
    v.push_back(mk(0, 0, 3'b000, 0, S_SRCH, R,  0, F,  80, 0));
    v.push_back(mk(0, 0, 3'b000, 0, S_SRCH, R, 50, F,  80, 0));
    for (int k = 5; k < 16; k++) v.push_back(mk(0, 0, 3'b000, 0, S_SRCH, R, 80, F, 80, 0));
    v.push_back(mk(0, 0, 3'b000, 0, S_IDLE, C, 0, C, 0, 1));
    v.push_back(mk(0, 0, 3'b000, 0, S_IDLE, C, 0, C, 0, 1));
    v.push_back(mk(0, 1, 3'b010, 0, S_FOL,  C, 0, C, 0, 0));
    v.push_back(mk(0, 0, 3'b010, 0, S_FOL,  F, 50, F, 50, 0));
    foreach (v[i]) begin
      sb.push_back(v[i].e);
      drive(v[i].s);
      got = observe();
      e   = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL search[%0d] got st=%0d ld=%b lu=%0d rd=%b ru=%0d lost=%b required st=%0d ld=%b lu=%0d rd=%b ru=%0d lost=%b",
                 i, got.st, got.ld, got.lu, got.rd, got.ru, got.lost, e.st, e.ld, e.lu, e.rd, e.ru, e.lost);
      end
    end
  endtask

  task automatic test_reset_midramp();
    step_t v[$];
    obs_t  got, e;
    v.push_back(mk(0, 0, 3'b010, 0, S_FOL,  F, 100, F, 100, 0));
    v.push_back(mk(1, 0, 3'b010, 0, S_IDLE, C,   0, C,   0, 0));
    v.push_back(mk(0, 1, 3'b010, 0, S_FOL,  C,   0, C,   0, 0));
    v.push_back(mk(0, 0, 3'b010, 0, S_FOL,  F,  50, F,  50, 0));
    v.push_back(mk(0, 1, 3'b010, 0, S_FOL,  F, 100, F, 100, 0));  // start ignored in FOLLOW
    v.push_back(mk(0, 0, 3'b010, 0, S_FOL,  F, 150, F, 150, 0));
    foreach (v[i]) begin
      sb.push_back(v[i].e);
      drive(v[i].s);
      got = observe();
      e   = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset_midramp[%0d] got st=%0d ld=%b lu=%0d rd=%b ru=%0d lost=%b required st=%0d ld=%b lu=%0d rd=%b ru=%0d lost=%b",
                 i, got.st, got.ld, got.lu, got.rd, got.ru, got.lost, e.st, e.ld, e.lu, e.rd, e.ru, e.lost);
      end
    end
  endtask

  task automatic test_start_with_obstacle();
    step_t v[$];
    obs_t  got, e;
    v.push_back(mk(1, 0, 3'b010, 0, S_IDLE, C, 0, C, 0, 0));
    v.push_back(mk(0, 0, 3'b010, 1, S_IDLE, C, 0, C, 0, 0));
    v.push_back(mk(0, 1, 3'b010, 1, S_FOL,  C, 0, C, 0, 0));
    v.push_back(mk(0, 0, 3'b010, 1, S_BRK,  B, 0, B, 0, 0));
    v.push_back(mk(0, 0, 3'b010, 0, S_BRK,  B, 0, B, 0, 0));
    foreach (v[i]) begin
      sb.push_back(v[i].e);
      drive(v[i].s);
      got = observe();
      e   = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL start_obstacle[%0d] got st=%0d ld=%b lu=%0d rd=%b ru=%0d lost=%b required st=%0d ld=%b lu=%0d rd=%b ru=%0d lost=%b",
                 i, got.st, got.ld, got.lu, got.rd, got.ru, got.lost, e.st, e.ld, e.lu, e.rd, e.ru, e.lost);
      end
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.sens_l   = 1'b0;
    bus.sens_m   = 1'b1;
    bus.sens_r   = 1'b0;
    bus.obstacle = 1'b0;
    test_reset();
    test_start_ramp();
    test_obstacle();
    test_steer();
    test_search();
    test_reset_midramp();
    test_start_with_obstacle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached after %0d comparisons", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
